// File: rtl/dino_pkg.sv
// dino_pkg: shared state codes, sprite ROM frame codes and datapath widths
// for the dino motion controller and its physics integrator.
package dino_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned FRAME_W  = 3;
  localparam int unsigned HEIGHT_W = 7;
  localparam int unsigned VEL_W    = 6;
  localparam int unsigned VPOS_W   = 9;
  localparam int unsigned ANIM_W   = 4;
  // Height + velocity sum: one bit of headroom over height plus a sign bit
  localparam int unsigned HSUM_W   = HEIGHT_W + 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DUCK = 3'd2,
    ST_AIR  = 3'd3,
    ST_DEAD = 3'd4
  } state_e;

  // Frame codes double as the sprite ROM frame index
  typedef enum logic [FRAME_W-1:0] {
    FR_STAND = 3'd0,
    FR_RUN0  = 3'd1,
    FR_RUN1  = 3'd2,
    FR_JUMP  = 3'd3,
    FR_DUCK0 = 3'd4,
    FR_DUCK1 = 3'd5,
    FR_DEAD  = 3'd6
  } frame_e;

  // Ground animation frame for a given pose and leg phase
  function automatic frame_e anim_frame(input logic duck, input logic phase);
    if (duck) return phase ? FR_DUCK1 : FR_DUCK0;
    return phase ? FR_RUN1 : FR_RUN0;
  endfunction

endpackage

// File: rtl/dino_physics.sv
// dino_physics: vertical height/velocity integrator for the dino.
// Ports:
//   clk, rst_n     clock, asynchronous active-high reset
//   tick_i         integrate one step (height += vel, vel -= gravity)
//   load_vel_i     load the jump launch velocity
//   cut_i          variable-jump cut: clamp upward velocity to 4 on this tick
//   freeze_i       hold height and velocity
//   clear_i        zero height and velocity (highest priority)
//   fast_i         double gravity on this tick (only with DINO_FASTFALL_EN)
//   height_c_o     next-cycle height (what the register takes on this edge)
//   landed_c_o     this tick brings the dino back to the ground
// Build option: DINO_FASTFALL_EN adds the fast_i fast-fall input.
module dino_physics
  import dino_pkg::*;
#(
  parameter logic [VEL_W-1:0]    JUMP_VEL   = 6'd12,
  parameter logic [VEL_W-1:0]    GRAVITY    = 6'd1,
  parameter logic [HEIGHT_W-1:0] MAX_HEIGHT = 7'd127
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                load_vel_i,
  input  logic                cut_i,
  input  logic                freeze_i,
  input  logic                clear_i,
`ifdef DINO_FASTFALL_EN
  input  logic                fast_i,
`endif
  output logic [HEIGHT_W-1:0] height_c_o,
  output logic                landed_c_o
);

  localparam logic signed [VEL_W-1:0]  VEL_CUT   = VEL_W'(4);
  localparam logic signed [VEL_W:0]    VEL_FLOOR = (VEL_W+1)'(-(2 ** (VEL_W - 1)));
  localparam logic signed [HSUM_W-1:0] H_MAX     = HSUM_W'(MAX_HEIGHT);

  logic [HEIGHT_W-1:0]      height_q, height_d;
  logic signed [VEL_W-1:0]  vel_q, vel_d;
  logic signed [VEL_W-1:0]  vel_eff;
  logic signed [HSUM_W-1:0] h_next;
  logic [VEL_W:0]           grav;
  logic signed [VEL_W:0]    vel_dec;
  logic signed [VEL_W:0]    vel_sat;
  logic                     h_at_ground;

  // One integration step: optional cut, height sum, gravity with floor saturation
  always_comb begin
    vel_eff     = (cut_i && (vel_q > VEL_CUT)) ? VEL_CUT : vel_q;
    h_next      = $signed(HSUM_W'(height_q)) + HSUM_W'(vel_eff);
    h_at_ground = h_next[HSUM_W-1] || (h_next == '0);
`ifdef DINO_FASTFALL_EN
    grav        = fast_i ? {GRAVITY, 1'b0} : {1'b0, GRAVITY};
`else
    grav        = {1'b0, GRAVITY};
`endif
    vel_dec     = (VEL_W+1)'(vel_eff) - $signed(grav);
    vel_sat     = (vel_dec < VEL_FLOOR) ? VEL_FLOOR : vel_dec;
  end

  // Control priority: clear > freeze > load > tick
  always_comb begin
    height_d   = height_q;
    vel_d      = vel_q;
    landed_c_o = 1'b0;
    if (clear_i) begin
      height_d = '0;
      vel_d    = '0;
    end else if (freeze_i) begin
      height_d = height_q;
    end else if (load_vel_i) begin
      vel_d = $signed(JUMP_VEL);
    end else if (tick_i) begin
      if (h_at_ground) begin
        height_d   = '0;
        vel_d      = '0;
        landed_c_o = 1'b1;
      end else begin
        height_d = (h_next > H_MAX) ? MAX_HEIGHT : HEIGHT_W'(h_next);
        vel_d    = VEL_W'(vel_sat);
      end
    end
  end

  assign height_c_o = height_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      height_q <= '0;
      vel_q    <= '0;
    end else begin
      height_q <= height_d;
      vel_q    <= vel_d;
    end
  end

endmodule

// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl: per-frame jump/duck/death state machine and run/duck
// animation for the player dino; drives sprite vertical position and ROM frame.
// Ports:
//   clk, rst_n     clock, asynchronous active-high reset
//   i_frame_tick   one-cycle pulse per video frame
//   i_jump         jump button level (synchronised)
//   i_duck         duck button level (synchronised)
//   i_collision    sprite overlap hit, any cycle
//   i_restart      restart request pulse (honoured in DEAD only)
//   o_dino_vpos    sprite top row = GROUND_VPOS - height
//   o_frame_sel    sprite ROM frame index
//   o_state        current state code
//   o_airborne     height nonzero or in AIR
// Build option: DINO_FASTFALL_EN doubles gravity while duck is held in AIR.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter logic [VPOS_W-1:0]   GROUND_VPOS    = 9'd200,
  parameter logic [VEL_W-1:0]    JUMP_VEL       = 6'd12,
  parameter logic [VEL_W-1:0]    GRAVITY        = 6'd1,
  parameter logic [HEIGHT_W-1:0] MAX_HEIGHT     = 7'd127,
  parameter logic [ANIM_W-1:0]   RUN_ANIM_TICKS = 4'd6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_frame_tick,
  input  logic              i_jump,
  input  logic              i_duck,
  input  logic              i_collision,
  input  logic              i_restart,
  output logic [VPOS_W-1:0] o_dino_vpos,
  output logic [2:0]        o_frame_sel,
  output logic [2:0]        o_state,
  output logic              o_airborne
);

  state_e              state_q;
  frame_e              frame_q;
  logic [ANIM_W-1:0]   anim_cnt_q;
  logic                anim_ph_q;
  logic                jump_latch_q;
  logic                jump_prev_q;
  logic [VPOS_W-1:0]   vpos_q;
  logic                airborne_q;

  logic                jump_edge;
  logic                hit;
  logic                restart;
  logic                tick_ok;
  logic                phy_tick;
  logic                phy_load;
  logic                phy_cut;
  logic                phy_freeze;
  logic                phy_clear;
  logic                anim_wrap;
  logic [ANIM_W-1:0]   anim_cnt_nxt;
  logic                anim_ph_nxt;
  logic [HEIGHT_W-1:0] height_c;
  logic                landed_c;

  // Event decode: restart beats collision, collision beats tick processing
  always_comb begin
    jump_edge  = i_jump && !jump_prev_q;
    hit        = i_collision &&
                 ((state_q == ST_RUN) || (state_q == ST_DUCK) || (state_q == ST_AIR));
    restart    = i_restart && (state_q == ST_DEAD);
    tick_ok    = i_frame_tick && !hit && (state_q != ST_DEAD);
    phy_clear  = restart;
    phy_freeze = hit || (state_q == ST_DEAD);
    phy_load   = tick_ok && jump_latch_q &&
                 ((state_q == ST_RUN) || (state_q == ST_DUCK));
    phy_tick   = tick_ok && (state_q == ST_AIR);
    phy_cut    = !i_jump;
  end

  // Leg animation: counter wraps after RUN_ANIM_TICKS ticks and flips the phase
  always_comb begin
    anim_wrap    = (anim_cnt_q == (RUN_ANIM_TICKS - ANIM_W'(1)));
    anim_cnt_nxt = anim_wrap ? '0 : (anim_cnt_q + ANIM_W'(1));
    anim_ph_nxt  = anim_ph_q ^ anim_wrap;
  end

  dino_physics #(
    .JUMP_VEL   (JUMP_VEL),
    .GRAVITY    (GRAVITY),
    .MAX_HEIGHT (MAX_HEIGHT)
  ) u_physics (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (phy_tick),
    .load_vel_i (phy_load),
    .cut_i      (phy_cut),
    .freeze_i   (phy_freeze),
    .clear_i    (phy_clear),
`ifdef DINO_FASTFALL_EN
    .fast_i     (i_duck),
`endif
    .height_c_o (height_c),
    .landed_c_o (landed_c)
  );

  // Motion FSM with jump latch, animation and registered sprite outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      frame_q      <= FR_STAND;
      anim_cnt_q   <= '0;
      anim_ph_q    <= 1'b0;
      jump_latch_q <= 1'b0;
      jump_prev_q  <= 1'b0;
      vpos_q       <= GROUND_VPOS;
      airborne_q   <= 1'b0;
    end else begin
      jump_prev_q <= i_jump;
      vpos_q      <= GROUND_VPOS - VPOS_W'(height_c);
      airborne_q  <= (height_c != '0);
      // Clears below are written later so they override a same-cycle set
      if (jump_edge) jump_latch_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (tick_ok && jump_latch_q) begin
            state_q      <= ST_RUN;
            jump_latch_q <= 1'b0;
            anim_cnt_q   <= '0;
            anim_ph_q    <= 1'b0;
            frame_q      <= FR_RUN0;
          end
        end

        ST_RUN, ST_DUCK: begin
          if (hit) begin
            state_q      <= ST_DEAD;
            jump_latch_q <= 1'b0;
            frame_q      <= FR_DEAD;
          end else if (tick_ok) begin
            if (jump_latch_q) begin
              state_q      <= ST_AIR;
              jump_latch_q <= 1'b0;
              anim_cnt_q   <= '0;
              anim_ph_q    <= 1'b0;
              frame_q      <= FR_JUMP;
              airborne_q   <= 1'b1;
            end else begin
              state_q    <= i_duck ? ST_DUCK : ST_RUN;
              anim_cnt_q <= anim_cnt_nxt;
              anim_ph_q  <= anim_ph_nxt;
              frame_q    <= anim_frame(i_duck, anim_ph_nxt);
            end
          end
        end

        ST_AIR: begin
          if (hit) begin
            state_q      <= ST_DEAD;
            jump_latch_q <= 1'b0;
            frame_q      <= FR_DEAD;
          end else if (landed_c) begin
            // Any jump pressed while airborne is dropped on touchdown
            state_q      <= ST_RUN;
            jump_latch_q <= 1'b0;
            anim_cnt_q   <= '0;
            anim_ph_q    <= 1'b0;
            frame_q      <= FR_RUN0;
          end else begin
            airborne_q <= 1'b1;
          end
        end

        ST_DEAD: begin
          if (restart) begin
            state_q      <= ST_IDLE;
            jump_latch_q <= 1'b0;
            anim_cnt_q   <= '0;
            anim_ph_q    <= 1'b0;
            frame_q      <= FR_STAND;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          jump_latch_q <= 1'b0;
          frame_q      <= FR_STAND;
        end
      endcase
    end
  end

  assign o_dino_vpos = vpos_q;
  assign o_frame_sel = frame_q;
  assign o_state     = state_q;
  assign o_airborne  = airborne_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed testbench for dino_motion_ctrl (default parameters).
module tb_dino_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_frame_tick;
  logic       i_jump;
  logic       i_duck;
  logic       i_collision;
  logic       i_restart;
  logic [8:0] o_dino_vpos;
  logic [2:0] o_frame_sel;
  logic [2:0] o_state;
  logic       o_airborne;

  int total;
  int bad;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_DUCK = 3'd2, S_AIR = 3'd3, S_DEAD = 3'd4;
  localparam logic [2:0] F_STAND = 3'd0, F_RUN0 = 3'd1, F_RUN1 = 3'd2, F_JUMP = 3'd3,
                         F_DUCK0 = 3'd4, F_DUCK1 = 3'd5, F_DEAD = 3'd6;
`ifdef DINO_FASTFALL_EN
  localparam int LAND_TICK = 22;
`else
  localparam int LAND_TICK = 25;
`endif

  dino_motion_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_tick (i_frame_tick),
    .i_jump       (i_jump),
    .i_duck       (i_duck),
    .i_collision  (i_collision),
    .i_restart    (i_restart),
    .o_dino_vpos  (o_dino_vpos),
    .o_frame_sel  (o_frame_sel),
    .o_state      (o_state),
    .o_airborne   (o_airborne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_tick();
    @(negedge clk) i_frame_tick = 1'b1;
    @(negedge clk) i_frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1; i_frame_tick = 1'b0; i_jump = 1'b0; i_duck = 1'b0;
    i_collision = 1'b0; i_restart = 1'b0;
    @(negedge clk) rst_n = 1'b0;
  endtask

  task automatic jump_edge();
    @(negedge clk) i_jump = 1'b0;
    @(negedge clk) i_jump = 1'b1;
  endtask

  task automatic start_run();
    jump_edge();
    do_tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; i_frame_tick = 1'b0; i_jump = 1'b0; i_duck = 1'b0;
    i_collision = 1'b0; i_restart = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (o_dino_vpos !== 9'd200) begin bad++; $display("FAIL reset_vpos got=%0d exp=200", o_dino_vpos); end
    total++; if (o_frame_sel !== F_STAND) begin bad++; $display("FAIL reset_frame got=%0d exp=0", o_frame_sel); end
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    total++; if (o_airborne !== 1'b0) begin bad++; $display("FAIL reset_airborne got=%0b exp=0", o_airborne); end
    rst_n = 1'b0;
  endtask

  task automatic test_run_anim();
    logic [2:0] exp_f;
    do_reset();
    start_run();
    total++; if (o_state !== S_RUN) begin bad++; $display("FAIL run_enter_state got=%0d exp=1", o_state); end
    total++; if (o_frame_sel !== F_RUN0) begin bad++; $display("FAIL run_enter_frame got=%0d exp=1", o_frame_sel); end
    for (int k = 1; k <= 12; k++) begin
      do_tick();
      exp_f = (((k / 6) % 2) == 1) ? F_RUN1 : F_RUN0;
      total++;
      if (o_frame_sel !== exp_f) begin bad++; $display("FAIL run_anim tick=%0d got=%0d exp=%0d", k, o_frame_sel, exp_f); end
    end
  endtask

  task automatic test_full_jump();
    int exp_h[25] = '{12,23,33,42,50,57,63,68,72,75,77,78,78,77,75,72,68,63,57,50,42,33,23,12,0};
    do_reset();
    start_run();
    jump_edge();
    do_tick();
    total++; if (o_state !== S_AIR) begin bad++; $display("FAIL jump_launch_state got=%0d exp=3", o_state); end
    total++; if (o_frame_sel !== F_JUMP) begin bad++; $display("FAIL jump_launch_frame got=%0d exp=3", o_frame_sel); end
    total++; if (o_airborne !== 1'b1) begin bad++; $display("FAIL jump_launch_airborne got=%0b exp=1", o_airborne); end
    for (int t = 1; t <= 25; t++) begin
      do_tick();
      total++;
      if (o_dino_vpos !== 9'(200 - exp_h[t-1])) begin
        bad++; $display("FAIL full_jump_vpos tick=%0d got=%0d exp=%0d", t, o_dino_vpos, 200 - exp_h[t-1]);
      end
    end
    total++; if (o_state !== S_RUN) begin bad++; $display("FAIL land_state got=%0d exp=1", o_state); end
    total++; if (o_airborne !== 1'b0) begin bad++; $display("FAIL land_airborne got=%0b exp=0", o_airborne); end
    total++; if (o_frame_sel !== F_RUN0) begin bad++; $display("FAIL land_frame got=%0d exp=1", o_frame_sel); end
  endtask

  task automatic test_short_hop();
    int exp_h[12] = '{16,19,21,22,22,21,19,16,12,7,1,0};
    do_reset();
    start_run();
    jump_edge();
    do_tick();
    do_tick();
    total++; if (o_dino_vpos !== 9'd188) begin bad++; $display("FAIL hop_first_vpos got=%0d exp=188", o_dino_vpos); end
    i_jump = 1'b0;
    for (int t = 0; t < 12; t++) begin
      do_tick();
      total++;
      if (o_dino_vpos !== 9'(200 - exp_h[t])) begin
        bad++; $display("FAIL short_hop_vpos tick=%0d got=%0d exp=%0d", t + 2, o_dino_vpos, 200 - exp_h[t]);
      end
    end
    total++; if (o_state !== S_RUN) begin bad++; $display("FAIL hop_land_state got=%0d exp=1", o_state); end
  endtask

  task automatic test_collision_air();
    do_reset();
    start_run();
    jump_edge();
    do_tick();
    for (int t = 0; t < 5; t++) do_tick();
    @(negedge clk) i_collision = 1'b1;
    @(negedge clk) i_collision = 1'b0;
    total++; if (o_state !== S_DEAD) begin bad++; $display("FAIL hit_air_state got=%0d exp=4", o_state); end
    total++; if (o_dino_vpos !== 9'd150) begin bad++; $display("FAIL hit_air_vpos got=%0d exp=150", o_dino_vpos); end
    total++; if (o_frame_sel !== F_DEAD) begin bad++; $display("FAIL hit_air_frame got=%0d exp=6", o_frame_sel); end
    total++; if (o_airborne !== 1'b1) begin bad++; $display("FAIL hit_air_airborne got=%0b exp=1", o_airborne); end
    for (int t = 1; t <= 10; t++) begin
      do_tick();
      total++;
      if (o_dino_vpos !== 9'd150 || o_state !== S_DEAD) begin
        bad++; $display("FAIL dead_frozen tick=%0d vpos=%0d state=%0d exp vpos=150 state=4", t, o_dino_vpos, o_state);
      end
    end
    @(negedge clk) i_restart = 1'b1;
    @(negedge clk) i_restart = 1'b0;
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL restart_state got=%0d exp=0", o_state); end
    total++; if (o_dino_vpos !== 9'd200) begin bad++; $display("FAIL restart_vpos got=%0d exp=200", o_dino_vpos); end
    total++; if (o_frame_sel !== F_STAND) begin bad++; $display("FAIL restart_frame got=%0d exp=0", o_frame_sel); end
    total++; if (o_airborne !== 1'b0) begin bad++; $display("FAIL restart_airborne got=%0b exp=0", o_airborne); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_run();
    jump_edge();
    // Tick with a pending jump and a collision together
    @(negedge clk) begin i_frame_tick = 1'b1; i_collision = 1'b1; end
    @(negedge clk) begin i_frame_tick = 1'b0; i_collision = 1'b0; end
    total++; if (o_state !== S_DEAD) begin bad++; $display("FAIL tick_hit_state got=%0d exp=4", o_state); end
    total++; if (o_dino_vpos !== 9'd200) begin bad++; $display("FAIL tick_hit_vpos got=%0d exp=200", o_dino_vpos); end
    total++; if (o_airborne !== 1'b0) begin bad++; $display("FAIL tick_hit_airborne got=%0b exp=0", o_airborne); end
    @(negedge clk) begin i_collision = 1'b1; i_restart = 1'b1; end
    @(negedge clk) begin i_collision = 1'b0; i_restart = 1'b0; end
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL hit_restart_state got=%0d exp=0", o_state); end
    total++; if (o_frame_sel !== F_STAND) begin bad++; $display("FAIL hit_restart_frame got=%0d exp=0", o_frame_sel); end
    @(negedge clk) i_collision = 1'b1;
    @(negedge clk) i_collision = 1'b0;
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL idle_hit_state got=%0d exp=0", o_state); end
    // Latch was dropped on DEAD entry and no new edge since, so IDLE holds
    do_tick();
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL idle_no_latch_state got=%0d exp=0", o_state); end
  endtask

  task automatic test_duck();
    do_reset();
    start_run();
    i_duck = 1'b1;
    do_tick();
    total++; if (o_state !== S_DUCK) begin bad++; $display("FAIL duck_state got=%0d exp=2", o_state); end
    total++; if (o_frame_sel !== F_DUCK0) begin bad++; $display("FAIL duck_frame0 got=%0d exp=4", o_frame_sel); end
    for (int t = 0; t < 5; t++) do_tick();
    total++; if (o_frame_sel !== F_DUCK1) begin bad++; $display("FAIL duck_frame1 got=%0d exp=5", o_frame_sel); end
    i_duck = 1'b0;
    do_tick();
    total++; if (o_state !== S_RUN || o_frame_sel !== F_RUN1) begin
      bad++; $display("FAIL unduck state=%0d frame=%0d exp state=1 frame=2", o_state, o_frame_sel);
    end
    i_duck = 1'b1;
    do_tick();
    jump_edge();
    do_tick();
    total++; if (o_state !== S_AIR || o_frame_sel !== F_JUMP) begin
      bad++; $display("FAIL duck_jump state=%0d frame=%0d exp state=3 frame=3", o_state, o_frame_sel);
    end
    i_duck = 1'b0;
  endtask

  task automatic test_reset_midjump();
    do_reset();
    start_run();
    jump_edge();
    do_tick();
    for (int t = 0; t < 3; t++) do_tick();
    total++; if (o_dino_vpos !== 9'd167) begin bad++; $display("FAIL pre_reset_vpos got=%0d exp=167", o_dino_vpos); end
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++; if (o_dino_vpos !== 9'd200) begin bad++; $display("FAIL midreset_vpos got=%0d exp=200", o_dino_vpos); end
    total++; if (o_frame_sel !== F_STAND) begin bad++; $display("FAIL midreset_frame got=%0d exp=0", o_frame_sel); end
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL midreset_state got=%0d exp=0", o_state); end
    rst_n = 1'b0;
  endtask

  task automatic test_fastfall();
    int land;
    int t;
    do_reset();
    start_run();
    jump_edge();
    do_tick();
    for (int k = 0; k < 12; k++) do_tick();
    total++; if (o_dino_vpos !== 9'd122) begin bad++; $display("FAIL ff_apex_vpos got=%0d exp=122", o_dino_vpos); end
    i_duck = 1'b1;
    land = 0;
    t = 12;
    while (land == 0 && t < 40) begin
      do_tick();
      t++;
      if (o_state !== S_AIR) land = t;
    end
    total++; if (land != LAND_TICK) begin bad++; $display("FAIL ff_land_tick got=%0d exp=%0d", land, LAND_TICK); end
    total++; if (o_state !== S_RUN || o_dino_vpos !== 9'd200) begin
      bad++; $display("FAIL ff_landed state=%0d vpos=%0d exp state=1 vpos=200", o_state, o_dino_vpos);
    end
    i_duck = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_run_anim();
    test_full_jump();
    test_short_hop();
    test_collision_air();
    test_simultaneous();
    test_duck();
    test_reset_midjump();
    test_fastfall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
